// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// Request/response bundle between the IFU, the LSU, the arbiter and the memory wrapper.
// The slave modport is the arbiter's view; the master modport is the requesters-plus-memory view.
interface ysyx_24100005_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction at a time,
// with a response timeout so a silent memory cannot hang the core.
module ysyx_24100005_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          rst,
  ysyx_24100005_mem_arbiter_if.slave   bus
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                owner_q;       // 1 = LSU owns the current transaction
  logic                last_grant_q;  // 1 = LSU was granted last
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          wmask_q;
  logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
  logic                ifu_err_q, lsu_err_q;

  logic                grant_ifu, grant_lsu;
  logic                accept, capture, cap_err;
  logic [DATA_W-1:0]   cap_data;

  // On contention the requester that was not served last wins.
  always_comb begin
    grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_grant_q);
    grant_ifu = bus.ifu_req_valid & ~grant_lsu;
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    accept   = 1'b0;
    capture  = 1'b0;
    cap_err  = 1'b0;
    cap_data = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_ifu | grant_lsu) begin
          accept  = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.mem_req_ready) begin
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        if (bus.mem_resp_valid) begin
          capture  = 1'b1;
          cap_data = wen_q ? '0 : bus.mem_rdata;
          state_d  = StResp;
        end else if ((TIMEOUT != 0) && (timer_q == TimerLast)) begin
          capture = 1'b1;
          cap_err = 1'b1;
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (accept) begin
        owner_q      <= grant_lsu;
        last_grant_q <= grant_lsu;
        addr_q       <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        wen_q        <= grant_lsu & bus.lsu_wen;
        wdata_q      <= grant_lsu ? bus.lsu_wdata : '0;
        wmask_q      <= grant_lsu ? bus.lsu_wmask : 8'h00;
      end
    end
  end

  // Per-requester response registers so each side keeps its last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q   <= 1'b0;
    end else if (capture) begin
      if (owner_q) begin
        lsu_rdata_q <= cap_data;
        lsu_err_q   <= cap_err;
      end else begin
        ifu_rdata_q <= cap_data;
        ifu_err_q   <= cap_err;
      end
    end
  end

  assign bus.ifu_req_ready  = (state_q == StIdle) & ~rst & grant_ifu;
  assign bus.lsu_req_ready  = (state_q == StIdle) & ~rst & grant_lsu;

  assign bus.ifu_resp_valid = (state_q == StResp) & ~owner_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_err_q;
  assign bus.lsu_resp_valid = (state_q == StResp) & owner_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_err_q;

  assign bus.mem_req_valid  = (state_q == StReq);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: directed requests, a memory model with
// programmable ready/response delays, and a negedge monitor that checks every response.
module tb_ysyx_24100005_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24100005_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {bit who; logic [31:0] rdata; bit err;} resp_t;
  typedef struct {logic [31:0] addr; bit wen; logic [31:0] wdata; logic [7:0] wmask;} mreq_t;

  resp_t resp_q[$];
  mreq_t mem_q[$];
  bit    grant_log[$];
  int    total = 0;
  int    bad   = 0;

  int          ready_delay = 0;
  int          resp_delay  = 0;
  int          stall       = 0;
  int          resp_cnt    = -1;
  bit          seen        = 0;
  mreq_t       snap;
  logic [31:0] resp_val    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0010_0093;
      32'h8000_0004: return 32'h0020_0113;
      32'h8000_0008: return 32'h0030_0193;
      32'h8000_2000: return 32'hCAFE_F00D;
      32'h8000_2004: return 32'h1234_5678;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory model: stalls ready, checks request fields, answers resp_delay cycles after accept.
  always @(negedge clk) begin
    mreq_t cur, e;
    if (rst) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      stall = 0; seen = 0; resp_cnt = -1;
    end else begin
      bus.mem_resp_valid = 1'b0;
      if (resp_cnt >= 0) begin
        if (resp_cnt == resp_delay) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = resp_val;
          resp_cnt           = -1;
        end else begin
          resp_cnt++;
        end
      end
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        cur.addr = bus.mem_addr; cur.wen = bus.mem_wen;
        cur.wdata = bus.mem_wdata; cur.wmask = bus.mem_wmask;
        if (!seen) begin
          seen = 1; snap = cur;
        end else begin
          check("mem hold addr/wdata", {cur.addr, cur.wdata}, {snap.addr, snap.wdata});
          check("mem hold wen/wmask", {cur.wen, cur.wmask}, {snap.wen, snap.wmask});
        end
        if (stall == ready_delay) begin
          bus.mem_req_ready = 1'b1;
          if (mem_q.size() == 0) begin
            check("mem unexpected req", 1, 0);
          end else begin
            e = mem_q.pop_front();
            check("mem addr", cur.addr, e.addr);
            check("mem wen", cur.wen, e.wen);
            check("mem wdata", cur.wdata, e.wdata);
            check("mem wmask", cur.wmask, e.wmask);
          end
          resp_val = cur.wen ? 32'hFFFF_FFFF : mem_lookup(cur.addr);
          resp_cnt = 0; stall = 0; seen = 0;
        end else begin
          stall++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever either side presents a response.
  always @(negedge clk) begin
    resp_t r;
    if (!rst) begin
      if (bus.ifu_req_ready && bus.lsu_req_ready) check("double grant", 1, 0);
      if (bus.ifu_req_ready) grant_log.push_back(1'b0);
      if (bus.lsu_req_ready) grant_log.push_back(1'b1);
      if (bus.ifu_resp_valid && bus.lsu_resp_valid) check("double resp", 1, 0);
      if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected resp", 1, 0);
        end else begin
          r = resp_q.pop_front();
          check("resp owner", {1'b0, bus.lsu_resp_valid}, {1'b0, r.who});
          if (bus.lsu_resp_valid) begin
            check("lsu rdata", bus.lsu_rdata, r.rdata);
            check("lsu err", bus.lsu_resp_err, r.err);
          end else begin
            check("ifu rdata", bus.ifu_rdata, r.rdata);
            check("ifu err", bus.ifu_resp_err, r.err);
          end
        end
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic ifu_read(input logic [31:0] a, input logic [31:0] exp_d, input bit exp_err,
                          input bit want);
    bit    done = 0;
    resp_t r;
    mreq_t m;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = a;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (bus.ifu_req_ready) begin
        done = 1;
        r.who = 1'b0; r.rdata = exp_d; r.err = exp_err;
        if (want) resp_q.push_back(r);
        m.addr = a; m.wen = 1'b0; m.wdata = '0; m.wmask = '0;
        mem_q.push_back(m);
        @(posedge clk);
        #1;
      end
    end
    bus.ifu_req_valid = 1'b0;
    if (!done) check("ifu accept timeout", 0, 1);
  endtask

  task automatic lsu_access(input logic [31:0] a, input bit wen, input logic [31:0] wd,
                            input logic [7:0] wm, input logic [31:0] exp_d, input bit exp_err);
    bit    done = 0;
    resp_t r;
    mreq_t m;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = a;
    bus.lsu_wen       = wen;
    bus.lsu_wdata     = wd;
    bus.lsu_wmask     = wm;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (bus.lsu_req_ready) begin
        done = 1;
        r.who = 1'b1; r.rdata = exp_d; r.err = exp_err;
        resp_q.push_back(r);
        m.addr = a; m.wen = wen; m.wdata = wd; m.wmask = wm;
        mem_q.push_back(m);
        @(posedge clk);
        #1;
      end
    end
    bus.lsu_req_valid = 1'b0;
    if (!done) check("lsu accept timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (resp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain", resp_q.size(), 0);
  endtask

  initial begin
    bit exp_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = '0;
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst mem_req_valid", bus.mem_req_valid, 0);
    check("rst mem_addr/wen", {bus.mem_addr, bus.mem_wen}, 0);
    check("rst resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    check("rst rdata", {bus.ifu_rdata, bus.lsu_rdata}, 0);
    check("rst err", {bus.ifu_resp_err, bus.lsu_resp_err}, 0);
    reset_dut();
    check("idle ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);

    // 1: single IFU read
    ifu_read(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b1);
    drain();
    check("ifu rdata hold", bus.ifu_rdata, 32'h0010_0093);
    check("lsu rdata untouched", bus.lsu_rdata, 0);

    // 2: both requesters continuously valid after reset
    reset_dut();
    grant_log.delete();
    fork
      begin
        ifu_read(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b1);
        ifu_read(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
      end
      begin
        lsu_access(32'h8000_2000, 1'b0, 32'h0, 8'h00, 32'hCAFE_F00D, 1'b0);
        lsu_access(32'h8000_2004, 1'b0, 32'h0, 8'h00, 32'h1234_5678, 1'b0);
      end
    join
    drain();
    check("grant count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check("grant order", grant_log[i], exp_order[i]);
    end

    // 3: store with mem_req_ready stalled for 3 cycles
    ready_delay = 3;
    lsu_access(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h01, 32'h0, 1'b0);
    drain();
    ready_delay = 0;

    // 6: long REQ stall must not time out
    ready_delay = 10;
    ifu_read(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
    drain();
    ready_delay = 0;

    // 4: timeout, late response ignored, then normal traffic
    resp_delay = 5;
    ifu_read(32'h8000_0008, 32'h0, 1'b1, 1'b1);
    drain();
    repeat (8) @(posedge clk);
    #1;
    check("ifu err hold", bus.ifu_resp_err, 1);
    check("ifu rdata after timeout", bus.ifu_rdata, 0);
    resp_delay = 0;
    lsu_access(32'h8000_2004, 1'b0, 32'h0, 8'h00, 32'h1234_5678, 1'b0);
    ifu_read(32'h8000_0008, 32'h0030_0193, 1'b0, 1'b1);
    drain();

    // 5: reset asserted mid-WAIT abandons the transaction
    resp_delay = 10;
    ifu_read(32'h8000_0000, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    #1;
    check("rst ready forced low", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    check("rst mid mem_req_valid", bus.mem_req_valid, 0);
    check("rst mid resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    rst = 1'b0;
    resp_delay = 0;
    ifu_read(32'h8000_0004, 32'h0020_0113, 1'b0, 1'b1);
    drain();
    repeat (4) @(posedge clk);
    check("mem queue empty", mem_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
